// File: rtl/lcd_time_monitor.sv
// rtl/lcd_time_monitor.sv - seven-segment clock display reader, decoder and sequence checker
// Optional: define LCD_MON_BLANK_EN to accept a blank (7'h00) tens digit as zero.
module lcd_time_monitor #(
  parameter int ERR_W   = 8,
  parameter int HRS_MOD = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hold,
  input  logic [6:0]       S1disp,
  input  logic [6:0]       S0disp,
  input  logic [6:0]       M1disp,
  input  logic [6:0]       M0disp,
  input  logic [6:0]       H1disp,
  input  logic [6:0]       H0disp,
  input  logic             AMorPM,
  output logic [6:0]       sec,
  output logic [6:0]       min,
  output logic [6:0]       hrs,
  output logic             pm,
  output logic             valid,
  output logic             err_seg,
  output logic             err_seq,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);

  localparam logic UNLOCKED = 1'b0;
  localparam logic LOCKED   = 1'b1;

  localparam logic [6:0] HRS_LIM = 7'(HRS_MOD);
  localparam logic [6:0] SIXTY   = 7'd60;

`ifdef LCD_MON_BLANK_EN
  localparam logic BLANK_OK = 1'b1;
`else
  localparam logic BLANK_OK = 1'b0;
`endif

  // Returns {legal, digit}; anything outside the ten glyphs is illegal.
  function automatic logic [4:0] seg_dec(input logic [6:0] p);
    case (p)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [6:0] field(input logic [3:0] t, input logic [3:0] o);
    return ({3'b000, t} * 7'd10) + {3'b000, o};
  endfunction

  logic       state;
  logic [4:0] d_s1, d_s0, d_m1, d_m0, d_h1, d_h0;
  logic [6:0] s_v, m_v, h_v;
  logic       legal;
  logic [6:0] nx_sec, nx_min, nx_hrs;
  logic       nx_pm;
  logic       match;
  logic [ERR_W-1:0] cnt_bump;

  // Only tens digits may be blank, and only when the feature is built in.
  assign d_s1 = (S1disp == 7'h00) ? {BLANK_OK, 4'd0} : seg_dec(S1disp);
  assign d_m1 = (M1disp == 7'h00) ? {BLANK_OK, 4'd0} : seg_dec(M1disp);
  assign d_h1 = (H1disp == 7'h00) ? {BLANK_OK, 4'd0} : seg_dec(H1disp);
  assign d_s0 = seg_dec(S0disp);
  assign d_m0 = seg_dec(M0disp);
  assign d_h0 = seg_dec(H0disp);

  assign s_v = field(d_s1[3:0], d_s0[3:0]);
  assign m_v = field(d_m1[3:0], d_m0[3:0]);
  assign h_v = field(d_h1[3:0], d_h0[3:0]);

  assign legal = d_s1[4] & d_s0[4] & d_m1[4] & d_m0[4] & d_h1[4] & d_h0[4] &
                 (s_v < SIXTY) & (m_v < SIXTY) & (h_v < HRS_LIM);

  always_comb begin
    nx_sec = sec + 7'd1;
    nx_min = min;
    nx_hrs = hrs;
    nx_pm  = pm;
    if (sec == 7'd59) begin
      nx_sec = 7'd0;
      if (min == 7'd59) begin
        nx_min = 7'd0;
        if (hrs == HRS_LIM - 7'd1) begin
          nx_hrs = 7'd0;
          nx_pm  = ~pm;
        end else begin
          nx_hrs = hrs + 7'd1;
        end
      end else begin
        nx_min = min + 7'd1;
      end
    end
  end

  assign match = (s_v == nx_sec) && (m_v == nx_min) && (h_v == nx_hrs) && (AMorPM == nx_pm);

  assign cnt_bump = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= UNLOCKED;
      sec     <= 7'd0;
      min     <= 7'd0;
      hrs     <= 7'd0;
      pm      <= 1'b0;
      valid   <= 1'b0;
      err_seg <= 1'b0;
      err_seq <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_seg <= 1'b0;
      err_seq <= 1'b0;
      if (en) begin
        if (!legal) begin
          // Decoded fields keep the last legal time for debug visibility.
          err_seg <= 1'b1;
          valid   <= 1'b0;
          state   <= UNLOCKED;
          err_cnt <= cnt_bump;
        end else begin
          sec   <= s_v;
          min   <= m_v;
          hrs   <= h_v;
          pm    <= AMorPM;
          valid <= 1'b1;
          state <= LOCKED;
          if ((state == LOCKED) && !hold && !match) begin
            err_seq <= 1'b1;
            err_cnt <= cnt_bump;
          end
        end
      end
    end
  end

endmodule

// File: doc/lcd_time_monitor.md
Name: lcd_time_monitor

Overview:
- Reader side of the clock's seven-segment display bus: samples the six digit outputs plus AMorPM, decodes them back to binary sec/min/hrs/pm, and checks that successive samples follow the legal time sequence.
- Used as an in-design self-checker and as the bench's scoreboard front end for the lab 2 clock top levels.
- Flags illegal segment patterns, out-of-range fields and sequence breaks, and keeps a saturating error count.

Parameters:
- ERR_W, 8, width of the saturating error counter.
- HRS_MOD, 12, hours modulus; the legal hours range is 0..HRS_MOD-1.

Ports:
- clk  input  1  system clock (same Pulse domain as the clock under check)
- rst  input  1  asynchronous reset, active-low
- en  input  1  sample strobe, one clk wide; a sample is taken only when en=1
- hold  input  1  1 = time being set; sample is decoded and resynced, but sequence is not checked
- S1disp, S0disp, M1disp, M0disp, H1disp, H0disp  input  7 each  segment patterns, bit order {g,f,e,d,c,b,a}, active-high
- AMorPM  input  1  PM indicator
- sec  output  7  decoded seconds
- min  output  7  decoded minutes
- hrs  output  7  decoded hours
- pm  output  1  decoded PM
- valid  output  1  decoded fields hold a legal sample
- err_seg  output  1  one-cycle pulse: illegal pattern or out-of-range field
- err_seq  output  1  one-cycle pulse: legal sample but not the expected successor
- err_cnt  output  ERR_W  saturating count of err_seg and err_seq events
- locked  output  1  monitor has a reference time

Behaviour:
- Segment decode: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F. Any other pattern is illegal.
- Field value = tens*10 + ones.
- Legal ranges: sec 0..59, min 0..59, hrs 0..HRS_MOD-1.
- Reset (rst=0, async):
  - sec/min/hrs=0, pm=0
  - valid=0, err_seg=0, err_seq=0, err_cnt=0, locked=0
  - FSM goes to UNLOCKED
- Latency: all outputs update on the clk edge where en=1; they are registered, one cycle after the inputs are presented. With en=0, decoded outputs hold and error pulses are 0.
- FSM state UNLOCKED:
  - Legal sample: load fields, valid=1, locked=1, go to LOCKED.
  - Illegal sample: err_seg=1, err_cnt++, valid=0, stay in UNLOCKED.
- FSM state LOCKED:
  - Expected successor of the stored time: sec+1. Carry from 59 to 0 increments min. Carry from min 59 with sec 59 increments hrs. Carry from hrs HRS_MOD-1 to 0 toggles pm.
  - Illegal sample: err_seg=1, err_cnt++, valid=0, go to UNLOCKED. Decoded outputs hold their last legal value.
  - Legal sample with hold=1: load fields, no check, no error.
  - Legal sample, hold=0, equals the expected successor: load fields, no error.
  - Legal sample, hold=0, any other value: err_seq=1, err_cnt++, load the observed value (resync), stay in LOCKED.
- err_seg and err_seq are never both 1 in the same cycle.
- err_cnt saturates at all-ones; it does not wrap.
- Full-day wrap 11:59:59 PM -> 00:00:00 AM is legal.
- Reset asserted mid-sequence clears everything immediately. The first legal sample after reset is never an error.

Optional Feature:
- Macro: LCD_MON_BLANK_EN.
- Defined: a tens digit (S1, M1, H1) equal to 7'h00 (blank) decodes as 0 and is legal. Blank ones digits remain illegal.
- Undefined: 7'h00 is illegal in every digit position.

Test Plan:
- Reset, then en with display 00:00:05 AM -> next cycle locked=1, valid=1, sec=5, no error pulse.
- Locked at 11:59:59 PM, next en with 00:00:00 AM -> hrs=0, pm=0, no error; then 00:00:01 AM -> no error.
- Locked at 03:10:20, en with 03:10:22, hold=0 -> err_seq=1 for one cycle, err_cnt=1, sec=22. Then 03:10:23 -> no error.
- Locked, en with S0disp=7'h49 -> err_seg=1, valid=0, locked=0, sec holds previous value. Next legal sample relocks with no error.
- hold=1 with sample jumps 01:00:00 -> 07:30:00 -> no errors, fields track. After hold drops, a correct successor gives no error.
- Drive 260 consecutive illegal samples -> err_cnt saturates at 255. With LCD_MON_BLANK_EN, H1disp=7'h00, H0disp=7'h66 decodes hrs=4 with no err_seg; without it, err_seg=1.
